// File: rtl/regfile_multiport.sv
// Parametrised multiport register file with optional write bypass and a per-register busy scoreboard.
// Writes, reserves and clears land one cycle after the edge; reads and bypass are combinational; no stalls or backpressure.
module regfile_multiport #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter bit BYPASS       = 1'b1,
    parameter bit ZERO_REG     = 1'b1,
    localparam int AW          = $clog2(NUM_REGS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en,
    input  logic [AW-1:0]                      wr_reg,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    input  logic                               rsv_en,
    input  logic [AW-1:0]                      rsv_reg,
    input  logic [NUM_RD_PORTS*AW-1:0]         rd_reg,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD_PORTS-1:0]            rd_busy,
    output logic [NUM_REGS-1:0]                busy_vec
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_nxt;
    logic                  wr_ok;
    logic                  rsv_ok;
    logic [AW-1:0]         rd_idx;

    assign wr_ok  = wr_en  && !(ZERO_REG && (wr_reg  == '0));
    assign rsv_ok = rsv_en && !(ZERO_REG && (rsv_reg == '0));

    // Reserve is applied after the write-clear so a new producer keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[wr_reg] = 1'b0;
        end
        if (rsv_ok) begin
            busy_nxt[rsv_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr_ok) begin
                regs[wr_reg] <= wr_data;
            end
            busy <= busy_nxt;
        end
    end

    assign busy_vec = busy;

    // Bypass uses raw wr_en so forwarding stays live during reset.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rd_idx  = '0;
        for (int i = 0; i < NUM_RD_PORTS; i++) begin
            rd_idx = rd_reg[i*AW +: AW];
            if (!(ZERO_REG && (rd_idx == '0))) begin
                if (BYPASS && wr_en && (wr_reg == rd_idx)) begin
                    rd_data[i*DATA_WIDTH +: DATA_WIDTH] = wr_data;
                end else begin
                    rd_data[i*DATA_WIDTH +: DATA_WIDTH] = regs[rd_idx];
                    rd_busy[i]                          = busy[rd_idx];
                end
            end
        end
    end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised successor to the two-read/one-write integer register file. It adds configurable data width, register count and read-port count, optional write-to-read bypass, synchronous clear on reset, and a per-register busy scoreboard for pipeline hazard detection. It sits in the decode stage of the core: issue logic reserves destination registers, writeback writes them, and decode reads operands and busy flags.

## Interface
- `DATA_WIDTH`, default 32: register width in bits.
- `NUM_REGS`, default 32: number of registers; must be a power of two and ≥ 2. `AW = $clog2(NUM_REGS)`.
- `NUM_RD_PORTS`, default 2: number of read ports; must be ≥ 1.
- `BYPASS`, default 1: when 1, a same-cycle write is forwarded to the read ports.
- `ZERO_REG`, default 1: when 1, register 0 is hardwired to zero and can never be reserved.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `wr_en`  in  1: write enable, active high.
- `wr_reg`  in  AW: write register index.
- `wr_data`  in  DATA_WIDTH: write data.
- `rsv_en`  in  1: reserve enable; marks `rsv_reg` busy.
- `rsv_reg`  in  AW: register index to reserve.
- `rd_reg`  in  NUM_RD_PORTS*AW: read indices; port i is `rd_reg[i*AW +: AW]`.
- `rd_data`  out  NUM_RD_PORTS*DATA_WIDTH: read data; port i is `rd_data[i*DATA_WIDTH +: DATA_WIDTH]`.
- `rd_busy`  out  NUM_RD_PORTS: busy flag for each read port's register.
- `busy_vec`  out  NUM_REGS: raw registered busy bits.

## Operation
- **Storage.** `NUM_REGS` × `DATA_WIDTH` flops plus `NUM_REGS` busy bits.
- **Write.** On a rising edge with `wr_en=1`, `regs[wr_reg] <= wr_data`.
  - If `ZERO_REG=1` and `wr_reg=0`, the write is dropped.
  - The write clears `busy[wr_reg]`, unless the reserve rule below keeps it set.
- **Reserve.** On a rising edge with `rsv_en=1`, `busy[rsv_reg] <= 1`.
  - Ignored when `ZERO_REG=1` and `rsv_reg=0`.
  - If a reserve and a write target the same register in the same cycle, the reserve wins: the data is written and busy stays 1, because a newer producer is now in flight.
  - Reserving a register that is already busy is legal; it stays busy.
- **Read (combinational).** For each port i:
  - If `ZERO_REG=1` and the index is 0, the port returns 0 and `rd_busy[i]=0`.
  - Else, if `BYPASS=1`, `wr_en=1`, and `wr_reg` equals the index, the port returns `wr_data` and `rd_busy[i]=0`.
  - Otherwise the port returns `regs[idx]` and `rd_busy[i]=busy[idx]`.
  - Any number of ports may read the same index.
- **`BYPASS=0`.** Reads return the pre-edge value. `rd_busy` reflects the registered busy bits only.
- **`busy_vec`.** Always equals the registered busy bits, with no bypass masking applied.
- **Reset.** With `rst=1` at a rising edge, all registers go to 0 and all busy bits go to 0.
  - Reset overrides a concurrent write and a concurrent reserve.
  - Reads during reset still follow the combinational rules above. Bypass stays active if `wr_en=1`.

## Timing
- Write latency: 1 cycle. Data is visible on the registered read path from the cycle after the edge.
- Bypass latency: 0 cycles. Data is visible in the same cycle it is presented.
- Busy set/clear latency: 1 cycle, edge to `busy_vec`.
- Reset values:
  - `busy_vec` = 0.
  - `rd_busy` = 0.
  - `rd_data` = 0 for every port after the reset edge, when no write is bypassing.
- No handshake and no stalls: every operation completes in the cycle it is presented.
- Out-of-range indices cannot occur, because `NUM_REGS` is a power of two.

## Test plan
- **Reset clear.** Write 0xDEADBEEF to x7 and reserve x9, then assert `rst` for 1 cycle. Required: x7 reads 0, `busy_vec` = 0.
- **Zero register.** Write 0xFFFFFFFF to x0 and reserve x0. Required: every port reads 0 at x0, `busy_vec[0]` = 0, `rd_busy` = 0.
- **Bypass.** With `BYPASS=1`, drive `wr_en=1`, `wr_reg=5`, `wr_data=0x12345678`, and all ports reading x5 in the same cycle. Required: every port returns 0x12345678 combinationally. With `BYPASS=0`, the ports return the old value in that cycle and 0x12345678 in the next cycle.
- **Scoreboard.** Reserve x3; the next cycle reads `rd_busy=1` at x3. Then write x3 = 0xA5A5A5A5 together with a reserve of x3. Required: the data is updated and busy stays 1. A later write to x3 alone clears busy.
- **Parameter sweep.** Run with DATA_WIDTH=64, NUM_REGS=16, NUM_RD_PORTS=4, ZERO_REG=0. Required: x0 is writable (write 0x1 reads back 0x1), and all four ports read independent indices correctly.
- **Random.** 10000 cycles of random writes, reserves, read indices, and occasional `rst`. Compare against a reference model of the registers and busy bits on every cycle, for every port. Required: 0 mismatches.
